// File: rtl/sim_pad_share_ctrl.sv
// sim_pad_share_ctrl: chip reset / strap sequencer and SPI-vs-JTAG pad arbiter
// for Verilator chip-level benches.
//
// After rst_i releases, por_n is held low for ResetHoldCycles, then the
// captured straps are driven for StrapHoldCycles. After that window the four
// shared DIO pads (SCK/CSB/SD0 out, SD1 in) are granted to either the SPI DPI
// or the JTAG DPI. An owner keeps the pads until it has been idle for
// IdleCycles consecutive cycles; every release parks the pads for one cycle.
//
// Optional feature (macro PADSHARE_TIMEOUT_EN): an owner that holds the pads
// for TimeoutCycles while the other side is waiting is forced off the pads,
// and the sticky timeout_o flag is raised.

module sim_pad_share_ctrl #(
    parameter int unsigned ResetHoldCycles = 16,
    parameter int unsigned StrapHoldCycles = 32,
    parameter int unsigned IdleCycles      = 4,
    parameter int unsigned JtagPriority    = 1,
    parameter int unsigned TimeoutCycles   = 4096
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] strap_i,
    output logic       chip_rst_no,
    output logic [3:0] strap_o,
    output logic       strap_en_o,
    output logic       strap_done_o,
    input  logic       spi_sck_i,
    input  logic       spi_csb_i,
    input  logic       spi_sdi_i,
    output logic       spi_sdo_o,
    input  logic       jtag_req_i,
    input  logic       jtag_tck_i,
    input  logic       jtag_tms_i,
    input  logic       jtag_tdi_i,
    output logic       jtag_tdo_o,
    output logic       pad_sck_o,
    output logic       pad_csb_o,
    output logic       pad_sd0_o,
    input  logic       pad_sd1_i,
    output logic [1:0] owner_o,
    output logic       timeout_o
);

    localparam int unsigned PhaseMax = (ResetHoldCycles > StrapHoldCycles) ?
                                       ResetHoldCycles : StrapHoldCycles;
    localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
    localparam int unsigned IdleW    = $clog2(IdleCycles + 1);

    localparam bit ParamsOk = (ResetHoldCycles >= 1) && (StrapHoldCycles >= 1) &&
                              (IdleCycles >= 1) && (JtagPriority <= 1) &&
                              (TimeoutCycles >= 1);

    // Reject unusable parameter sets at elaboration.
    if (!ParamsOk) begin : g_param_check
        $error("sim_pad_share_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_STRAP    = 3'd1,
        ST_IDLE     = 3'd2,
        ST_OWN_SPI  = 3'd3,
        ST_OWN_JTAG = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_SPI  = 2'd1,
        OWN_JTAG = 2'd2
    } owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner_q, last_owner_d;
    logic [PhaseW-1:0] phase_cnt_q, phase_cnt_d;
    logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;
    logic              chip_rst_n_q, chip_rst_n_d;
    logic              strap_en_q, strap_en_d;
    logic              strap_done_q, strap_done_d;
    logic [3:0]        strap_q;

    logic              spi_req;
    logic              jtag_req;
    logic [PhaseW-1:0] phase_inc;
    logic [IdleW-1:0]  idle_inc;
    logic              owner_idle;
    logic              other_pend;
    logic              idle_rel;
    logic              force_rel;

`ifdef PADSHARE_TIMEOUT_EN
    localparam int unsigned HoldW = $clog2(TimeoutCycles + 1);

    logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [HoldW-1:0]  hold_inc;
    logic              timeout_q, timeout_d;
`endif

    assign spi_req  = ~spi_csb_i;
    assign jtag_req = jtag_req_i;

    // Next-state logic for the sequencer, arbiter and all counters.
    always_comb begin
        // NOTE: every _d gets its current value first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        phase_cnt_d  = phase_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        chip_rst_n_d = chip_rst_n_q;
        strap_en_d   = strap_en_q;
        strap_done_d = strap_done_q;

        phase_inc  = (phase_cnt_q == {PhaseW{1'b1}}) ? phase_cnt_q : phase_cnt_q + 1'b1;
        idle_inc   = (idle_cnt_q == {IdleW{1'b1}}) ? idle_cnt_q : idle_cnt_q + 1'b1;
        owner_idle = (state_q == ST_OWN_SPI) ? ~spi_req : ~jtag_req;
        other_pend = (state_q == ST_OWN_SPI) ? jtag_req : spi_req;
        idle_rel   = owner_idle && (idle_inc == IdleW'(IdleCycles));

`ifdef PADSHARE_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = timeout_q;
        hold_inc   = (hold_cnt_q == {HoldW{1'b1}}) ? hold_cnt_q : hold_cnt_q + 1'b1;
        force_rel  = 1'b0;
        if (state_q == ST_OWN_SPI || state_q == ST_OWN_JTAG) begin
            hold_cnt_d = other_pend ? hold_inc : '0;
            force_rel  = other_pend && (hold_inc == HoldW'(TimeoutCycles));
        end else begin
            hold_cnt_d = '0;
        end
`else
        force_rel = 1'b0;
`endif

        case (state_q)
            ST_RST_HOLD: begin
                phase_cnt_d = phase_inc;
                if (phase_inc == PhaseW'(ResetHoldCycles)) begin
                    chip_rst_n_d = 1'b1;
                    phase_cnt_d  = '0;
                    state_d      = ST_STRAP;
                end
            end

            ST_STRAP: begin
                phase_cnt_d = phase_inc;
                if (phase_inc == PhaseW'(StrapHoldCycles)) begin
                    strap_en_d   = 1'b0;
                    strap_done_d = 1'b1;
                    phase_cnt_d  = '0;
                    state_d      = ST_IDLE;
                end
            end

            ST_IDLE: begin
                idle_cnt_d = '0;
                if (spi_req && jtag_req) begin
                    if (last_owner_q == OWN_SPI) begin
                        owner_d = OWN_JTAG;
                    end else if (last_owner_q == OWN_JTAG) begin
                        owner_d = OWN_SPI;
                    end else begin
                        owner_d = (JtagPriority != 0) ? OWN_JTAG : OWN_SPI;
                    end
                end else if (spi_req) begin
                    owner_d = OWN_SPI;
                end else if (jtag_req) begin
                    owner_d = OWN_JTAG;
                end
                if (owner_d == OWN_SPI) begin
                    state_d = ST_OWN_SPI;
                end else if (owner_d == OWN_JTAG) begin
                    state_d = ST_OWN_JTAG;
                end
            end

            ST_OWN_SPI, ST_OWN_JTAG: begin
                idle_cnt_d = owner_idle ? idle_inc : '0;
                if (idle_rel || force_rel) begin
                    last_owner_d = owner_q;
                    owner_d      = OWN_NONE;
                    idle_cnt_d   = '0;
                    state_d      = ST_IDLE;
`ifdef PADSHARE_TIMEOUT_EN
                    hold_cnt_d = '0;
                    if (force_rel) begin
                        timeout_d = 1'b1;
                    end
`endif
                end
            end

            default: begin
                state_d = ST_RST_HOLD;
            end
        endcase
    end

    // State register; a sampled rst_i restarts the whole sequence and
    // recaptures the straps.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values computed above.
        if (rst_i) begin
            state_q      <= ST_RST_HOLD;
            owner_q      <= OWN_NONE;
            last_owner_q <= OWN_NONE;
            phase_cnt_q  <= '0;
            idle_cnt_q   <= '0;
            chip_rst_n_q <= 1'b0;
            strap_en_q   <= 1'b1;
            strap_done_q <= 1'b0;
            // NOTE: the strap register is loaded (not cleared) by reset: its
            // whole purpose is to hold what strap_i showed while rst_i was high.
            strap_q      <= strap_i;
`ifdef PADSHARE_TIMEOUT_EN
            hold_cnt_q   <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            phase_cnt_q  <= phase_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            chip_rst_n_q <= chip_rst_n_d;
            strap_en_q   <= strap_en_d;
            strap_done_q <= strap_done_d;
`ifdef PADSHARE_TIMEOUT_EN
            hold_cnt_q   <= hold_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    // Pad mux, steered by the registered owner; parked when nobody owns.
    always_comb begin
        pad_sck_o  = 1'b0;
        pad_csb_o  = 1'b1;
        pad_sd0_o  = 1'b0;
        spi_sdo_o  = 1'b0;
        jtag_tdo_o = 1'b0;
        case (owner_q)
            OWN_SPI: begin
                pad_sck_o = spi_sck_i;
                pad_csb_o = spi_csb_i;
                pad_sd0_o = spi_sdi_i;
                spi_sdo_o = pad_sd1_i;
            end
            OWN_JTAG: begin
                pad_sck_o  = jtag_tck_i;
                pad_csb_o  = jtag_tms_i;
                pad_sd0_o  = jtag_tdi_i;
                jtag_tdo_o = pad_sd1_i;
            end
            default: begin
            end
        endcase
    end

    assign chip_rst_no  = chip_rst_n_q;
    assign strap_o      = strap_q;
    assign strap_en_o   = strap_en_q;
    assign strap_done_o = strap_done_q;
    assign owner_o      = owner_q;

`ifdef PADSHARE_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
